// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: ROB tag width, default FU count and the broadcast packet.
// Imported by the arbiter, its interface, and the map table / ROB / RS consumers.
package cdb_arbiter_pkg;

  localparam int ROB_TAG_LEN    = 5;
  localparam int NUM_FU_DEFAULT = 4;
  localparam int XLEN           = 32;

  // Tag 0 is never issued by the ROB, so an idle bus reads as tag 0 / valid 0.
  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } cdb_packet_t;

  localparam cdb_packet_t CDB_IDLE = '0;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit completion bus: per-FU request/tag/value, grant vector and CDB broadcast.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU_DEFAULT
);
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]                  fu_req;
  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] fu_rob_tag;
  logic [NUM_FU-1:0][XLEN-1:0]        fu_value;
  logic [NUM_FU-1:0]                  fu_grant;
  cdb_packet_t                        cdb_packet;

  modport master (
    output fu_req, fu_rob_tag, fu_value,
    input  fu_grant, cdb_packet
  );

  modport slave (
    input  fu_req, fu_rob_tag, fu_value,
    output fu_grant, cdb_packet
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode. Finds the first set bit of req
// searching upward from ptr with wrap; returns one-hot grant, its index and an any flag.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned; otherwise synthesis infers latches.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one FU per cycle and registers the winner onto the CDB.
// Round-robin by default; define CDB_FIXED_PRI_EN for fixed priority (FU0 highest).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] req_eff;
  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  pick_ptr;
  logic              grant_any;

  // Reset and squash both suppress arbitration for the current cycle.
  assign req_eff = bus.fu_req & ~{NUM_FU{squash | reset}};

`ifdef CDB_FIXED_PRI_EN
  assign pick_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= PTR_W'(next_idx(int'(grant_idx), NUM_FU));
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  rr_pick #(
    .N (NUM_FU)
  ) u_rr_pick (
    .req   (req_eff),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign bus.fu_grant = grant;

  always_ff @(posedge clock) begin
    if (reset || !grant_any) begin
      bus.cdb_packet <= CDB_IDLE;
    end else begin
      bus.cdb_packet.valid   <= 1'b1;
      bus.cdb_packet.rob_tag <= bus.fu_rob_tag[grant_idx];
      bus.cdb_packet.value   <= bus.fu_value[grant_idx];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then randomized FU traffic,
// compared against a behavioural arbitration model (round-robin or CDB_FIXED_PRI_EN).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic squash;

  cdb_arbiter_if #(.NUM_FU(N)) bus ();

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int          vectors    = 0;
  int          miscompares = 0;
  int          m_ptr      = 0;
  logic [N-1:0] pending;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: inputs on bus are already set; reset/squash applied here.
  // Checks grant mid-cycle and the registered packet just after the next edge.
  task automatic step(input logic rst, input logic sq, output int gi);
    logic [N-1:0] eg;
    cdb_packet_t  ep;
    reset  = rst;
    squash = sq;
    #1;
    gi = -1;
    if (!rst && !sq) begin
      for (int k = 0; k < N; k++) begin
        int j;
        `ifdef CDB_FIXED_PRI_EN
        j = k;
        `else
        j = (m_ptr + k) % N;
        `endif
        if (gi < 0 && bus.fu_req[j]) gi = j;
      end
    end
    eg = (gi < 0) ? '0 : N'(1) << gi;
    check("fu_grant", 64'(bus.fu_grant), 64'(eg));
    if (gi < 0) ep = '0;
    else begin
      ep.valid   = 1'b1;
      ep.rob_tag = bus.fu_rob_tag[gi];
      ep.value   = bus.fu_value[gi];
    end
    if (rst) m_ptr = 0;
    else if (gi >= 0) m_ptr = (gi + 1) % N;
    @(posedge clock);
    #1;
    check("cdb_packet", 64'(bus.cdb_packet), 64'(ep));
  endtask

  task automatic set_fu(input int i, input logic r, input logic [ROB_TAG_LEN-1:0] t,
                        input logic [31:0] v);
    bus.fu_req[i]     = r;
    bus.fu_rob_tag[i] = t;
    bus.fu_value[i]   = v;
  endtask

  initial begin
    int g;
    reset          = 1'b1;
    squash         = 1'b0;
    bus.fu_req     = '0;
    bus.fu_rob_tag = '0;
    bus.fu_value   = '0;
    pending        = '0;
    @(posedge clock);
    #1;

    // Reset cycles, one with requests present, then idle bus for 5 cycles.
    step(1'b1, 1'b0, g);
    bus.fu_req = '1;
    step(1'b1, 1'b0, g);
    bus.fu_req = '0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, g);

    // Single request from FU2.
    set_fu(2, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, g);
    bus.fu_req = '0;
    step(1'b0, 1'b0, g);

    // Wrap-around: pointer now past FU2, requests on FU0 and FU1.
    set_fu(0, 1'b1, 5'd3, 32'h0000_1111);
    set_fu(1, 1'b1, 5'd4, 32'h0000_2222);
    step(1'b0, 1'b0, g);
    if (g >= 0) bus.fu_req[g] = 1'b0;
    step(1'b0, 1'b0, g);
    bus.fu_req = '0;

    // Pointer back to 0, then all four FUs held requesting.
    step(1'b1, 1'b0, g);
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, ROB_TAG_LEN'(i + 9), 32'hA000_0000 + i);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, g);
    bus.fu_req = '0;
    step(1'b0, 1'b0, g);

    // Squash with FU1 requesting, then FU1 granted the following cycle.
    set_fu(1, 1'b1, 5'd12, 32'h1234_5678);
    step(1'b0, 1'b1, g);
    step(1'b0, 1'b0, g);
    bus.fu_req = '0;

    // Reset while FU3 requests and a packet is in flight.
    set_fu(0, 1'b1, 5'd20, 32'hCAFE_F00D);
    step(1'b0, 1'b0, g);
    bus.fu_req = '0;
    set_fu(3, 1'b1, 5'd21, 32'h0BAD_F00D);
    step(1'b1, 1'b0, g);
    step(1'b0, 1'b0, g);
    bus.fu_req = '0;

    // Randomized traffic obeying the hold-until-granted handshake.
    for (int c = 0; c < 400; c++) begin
      logic rst_r, sq_r;
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i]        = 1'b1;
          bus.fu_rob_tag[i] = ROB_TAG_LEN'($urandom_range(1, (1 << ROB_TAG_LEN) - 1));
          bus.fu_value[i]   = $urandom;
        end
      end
      bus.fu_req = pending;
      rst_r = ($urandom_range(0, 39) == 0);
      sq_r  = ($urandom_range(0, 15) == 0);
      step(rst_r, sq_r, g);
      if (g >= 0) pending[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
